// File: rtl/axis_image_unpacker_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_image_unpacker_if
//  Purpose  : AXI-Stream image word channel between the MM2S DMA read side
//             (master) and the image unpacker (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface axis_image_unpacker_if;
   logic [127:0] AxisData;
   logic         AxisDataVld;
   logic         AxisDataEnd;
   logic         AxisDataRead;

   modport master (output AxisData, output AxisDataVld, output AxisDataEnd,
                   input  AxisDataRead);
   modport slave  (input  AxisData, input  AxisDataVld, input  AxisDataEnd,
                   output AxisDataRead);
endinterface
`default_nettype wire

// File: rtl/axis_image_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : axis_image_unpacker
//  Purpose  : Unpacks 128-bit DMA stream words into 8-lane x 10-bit pixel
//             beats (8-bit or 10-bit packing), tracks line/column position,
//             marks line start / frame end and flags stream framing errors.
//  Options  : define AXIS_LAST_CHECK_EN to enable tlast framing checks
//             (status[2] missing_last, status[1] early_last).
//  Revision : 1.0  initial release
// ============================================================================
module axis_image_unpacker #(
   parameter int LANE   = 8,
   parameter int DWIDTH = 10
) (
   input  logic                     sys_clk,
   input  logic                     frame_rst,
   axis_image_unpacker_if.slave     axis,
   input  logic [31:0]              imageWidth,
   input  logic [31:0]              imageHeight,
   input  logic                     imageMode,
   input  logic                     playEnable,
   input  logic                     lane_rdy,
   output logic [LANE*DWIDTH-1:0]   dataOut,
   output logic                     data_vld,
   output logic                     line_start,
   output logic                     frame_end,
   output logic [2:0]               status,
   output logic [31:0]              inDataCount
);

   // Frame configuration, frozen outside reset
   logic         mode_q;
   logic [31:0]  width_q;
   logic [31:0]  height_q;

   // Holding register and position state
   logic [127:0] hold;
   logic         hv;
   logic         hp;
   logic [31:0]  col_cnt;
   logic [31:0]  line_cnt;
   logic         done;
   logic         started;
   logic         underrun;
   logic         early_last;
   logic         missing_last;

   logic                   accept;
   logic                   consume;
   logic                   last_beat;
   logic [31:0]            cols;
   logic                   line_end;
   logic                   frame_last;
   logic [31:0]            word_pix;
   logic [63:0]            half;
   logic [LANE*DWIDTH-1:0] beat;

   assign cols       = {3'b000, width_q[31:3]};
   assign last_beat  = mode_q | hp;
   assign consume    = hv & lane_rdy;
   assign axis.AxisDataRead = playEnable & ~done & (~hv | (lane_rdy & last_beat));
   assign accept     = axis.AxisDataVld & axis.AxisDataRead;
   assign line_end   = (col_cnt == cols);
   assign frame_last = line_end & (line_cnt == height_q);
   assign word_pix   = mode_q ? 32'd8 : 32'd16;
   assign half       = hp ? hold[127:64] : hold[63:0];
   assign status     = {missing_last, early_last, underrun};

   // Slot i of the word (byte in 8-bit mode, 16-bit slot in 10-bit mode)
   // lands on lane LANE-1-i, so the first pixel of the word is the top lane.
   for (genvar i = 0; i < LANE; i++) begin : g_lane
      assign beat[(LANE-1-i)*DWIDTH +: DWIDTH] =
         mode_q ? hold[16*i +: DWIDTH] : {half[8*i +: 8], 2'b00};
   end

   // Sample frame geometry and packing mode while the frame is held in reset
   always_ff @(posedge sys_clk) begin
      if (frame_rst) begin
         mode_q   <= imageMode;
         width_q  <= imageWidth;
         height_q <= imageHeight;
      end
   end

   // Word holding, beat generation, line/column tracking and underrun flag
   always_ff @(posedge sys_clk or posedge frame_rst) begin
      if (frame_rst) begin
         hold        <= '0;
         hv          <= 1'b0;
         hp          <= 1'b0;
         col_cnt     <= 32'd1;
         line_cnt    <= 32'd1;
         done        <= 1'b0;
         started     <= 1'b0;
         underrun    <= 1'b0;
         inDataCount <= '0;
         dataOut     <= '0;
         data_vld    <= 1'b0;
         line_start  <= 1'b0;
         frame_end   <= 1'b0;
      end else begin
         data_vld   <= consume;
         line_start <= consume & (col_cnt == 32'd1);
         frame_end  <= consume & frame_last;
         if (consume)
            dataOut <= beat;

         // A new word may land in the same cycle the old word's last beat leaves
         if (accept) begin
            hold        <= axis.AxisData;
            hv          <= 1'b1;
            hp          <= 1'b0;
            started     <= 1'b1;
            inDataCount <= inDataCount + word_pix;
         end else if (consume) begin
            if (last_beat)
               hv <= 1'b0;
            else
               hp <= 1'b1;
         end

         if (consume) begin
            if (line_end) begin
               col_cnt  <= 32'd1;
               line_cnt <= line_cnt + 32'd1;
            end else begin
               col_cnt  <= col_cnt + 32'd1;
            end
            if (frame_last)
               done <= 1'b1;
         end

         if (lane_rdy & ~hv & ~done & playEnable & started)
            underrun <= 1'b1;
      end
   end

`ifdef AXIS_LAST_CHECK_EN
   logic [31:0] frame_pix_q;
   logic        final_word;

   assign final_word = ((inDataCount + word_pix) == frame_pix_q);

   // Total frame size is precomputed while in reset to keep the multiply off the stream path
   always_ff @(posedge sys_clk) begin
      if (frame_rst)
         frame_pix_q <= imageWidth * imageHeight;
   end

   // Sticky tlast framing checks against the expected final word of the frame
   always_ff @(posedge sys_clk or posedge frame_rst) begin
      if (frame_rst) begin
         early_last   <= 1'b0;
         missing_last <= 1'b0;
      end else begin
         if (accept & axis.AxisDataEnd & ~final_word)
            early_last <= 1'b1;
         if (accept & ~axis.AxisDataEnd & final_word)
            missing_last <= 1'b1;
      end
   end
`else
   // tlast is not checked in this build
   logic unused_ok;
   assign unused_ok    = &{1'b0, axis.AxisDataEnd, width_q[2:0]};
   assign early_last   = 1'b0;
   assign missing_last = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_image_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_image_unpacker
//  Purpose  : Self-checking bench for axis_image_unpacker; expected beats are
//             derived from the pixel layout of each word, frame geometry and
//             the configured packing mode.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_image_unpacker;

   typedef struct packed {
      logic [79:0] d;
      logic        ls;
      logic        fe;
   } beat_t;

   logic        sys_clk = 1'b0;
   logic        frame_rst = 1'b1;
   logic [31:0] imageWidth = 32'd16;
   logic [31:0] imageHeight = 32'd1;
   logic        imageMode = 1'b1;
   logic        playEnable = 1'b0;
   logic        lane_rdy = 1'b0;
   logic [79:0] dataOut;
   logic        data_vld;
   logic        line_start;
   logic        frame_end;
   logic [2:0]  status;
   logic [31:0] inDataCount;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int nbeats = 0;
   int first_beat = -1;
   int last_beat = -1;
   beat_t expq[$];
   beat_t mon_e;

   axis_image_unpacker_if axis ();

   axis_image_unpacker dut (
      .sys_clk     (sys_clk),
      .frame_rst   (frame_rst),
      .axis        (axis),
      .imageWidth  (imageWidth),
      .imageHeight (imageHeight),
      .imageMode   (imageMode),
      .playEnable  (playEnable),
      .lane_rdy    (lane_rdy),
      .dataOut     (dataOut),
      .data_vld    (data_vld),
      .line_start  (line_start),
      .frame_end   (frame_end),
      .status      (status),
      .inDataCount (inDataCount)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output monitor: every valid beat is matched against the reference queue
   always begin
      @(posedge sys_clk);
      #1;
      if (data_vld === 1'b1) begin
         if (expq.size() == 0) begin
            chk("extra_beat", 80'd1, 80'd0);
         end else begin
            mon_e = expq.pop_front();
            chk("beat_data", dataOut, mon_e.d);
            chk("line_start", {79'd0, line_start}, {79'd0, mon_e.ls});
            chk("frame_end", {79'd0, frame_end}, {79'd0, mon_e.fe});
         end
         nbeats++;
         if (first_beat < 0) first_beat = cyc;
         last_beat = cyc;
      end
   end

   function automatic logic pick_rdy(input int rdy_mode, input int t);
      if (rdy_mode == 0) return 1'b1;
      if (rdy_mode == 1) return (t % 2) == 0;
      return 1'($urandom_range(0, 1));
   endfunction

   // pat: 0 random, 1 slot0=0x3FF only, 2 byte ramp 0x00..0x0F
   task automatic run_frame(input logic mode, input int width, input int height,
                            input int rdy_mode, input int gap_at, input int early_idx,
                            input bit final_last, input int pat, input int abort_at);
      logic [127:0] words[$];
      logic [127:0] w;
      beat_t        b;
      int ppw, nwords, nb, bpl, sent, guard, first_acc, gap_left, bi;
      logic exp_early, exp_missing;

      @(negedge sys_clk);
      frame_rst = 1'b1;
      playEnable = 1'b0;
      imageMode = mode;
      imageWidth = width;
      imageHeight = height;
      axis.AxisDataVld = 1'b0;
      axis.AxisDataEnd = 1'b0;
      lane_rdy = 1'b0;
      repeat (2) @(negedge sys_clk);
      expq.delete();
      nbeats = 0;
      first_beat = -1;
      last_beat = -1;

      ppw = mode ? 8 : 16;
      nwords = width * height / ppw;
      bpl = width / 8;
      nb = width * height / 8;
      bi = 0;
      for (int k = 0; k < nwords; k++) begin
         if (pat == 1)      w = 128'h3FF;
         else if (pat == 2) for (int j = 0; j < 16; j++) w[8*j +: 8] = 8'(j);
         else               w = {$urandom, $urandom, $urandom, $urandom};
         words.push_back(w);
         for (int h = 0; h < (mode ? 1 : 2); h++) begin
            for (int i = 0; i < 8; i++) begin
               if (mode) b.d[(7-i)*10 +: 10] = w[16*i +: 10];
               else      b.d[(7-i)*10 +: 10] = {w[64*h + 8*i +: 8], 2'b00};
            end
            b.ls = (bi % bpl) == 0;
            b.fe = (bi == nb - 1);
            expq.push_back(b);
            bi++;
         end
      end

      frame_rst = 1'b0;
      playEnable = 1'b1;
      sent = 0;
      guard = 0;
      first_acc = -1;
      gap_left = 3;
      while (sent < nwords && guard < 4000) begin
         if (abort_at >= 0 && sent == abort_at) begin
            frame_rst = 1'b1;
            playEnable = 1'b0;
            axis.AxisDataVld = 1'b0;
            #1;
            chk("abort_dataOut", dataOut, 80'd0);
            chk("abort_vld", {79'd0, data_vld}, 80'd0);
            chk("abort_ls_fe", {78'd0, line_start, frame_end}, 80'd0);
            chk("abort_status", {77'd0, status}, 80'd0);
            chk("abort_count", {48'd0, inDataCount}, 80'd0);
            chk("abort_ready", {79'd0, axis.AxisDataRead}, 80'd0);
            expq.delete();
            return;
         end
         lane_rdy = pick_rdy(rdy_mode, guard);
         if (gap_at == sent && gap_left > 0) begin
            axis.AxisDataVld = 1'b0;
            axis.AxisDataEnd = 1'b0;
            lane_rdy = 1'b1;
            gap_left--;
         end else begin
            axis.AxisDataVld = 1'b1;
            axis.AxisData = words[sent];
            axis.AxisDataEnd = (sent == early_idx) || (sent == nwords - 1 && final_last);
         end
         #1;
         if (axis.AxisDataVld && axis.AxisDataRead) begin
            if (first_acc < 0) first_acc = cyc;
            sent++;
         end
         @(negedge sys_clk);
         guard++;
      end
      axis.AxisDataVld = 1'b0;
      axis.AxisDataEnd = 1'b0;
      chk("feed_words", 80'(sent), 80'(nwords));

      guard = 0;
      while (expq.size() != 0 && guard < 500) begin
         lane_rdy = pick_rdy(rdy_mode, guard);
         @(negedge sys_clk);
         guard++;
      end
      chk("drain_left", 80'(expq.size()), 80'd0);
      lane_rdy = 1'b1;
      repeat (2) @(negedge sys_clk);
      chk("beats", 80'(nbeats), 80'(nb));
      chk("inDataCount", {48'd0, inDataCount}, 80'(nwords * ppw));

`ifdef AXIS_LAST_CHECK_EN
      exp_early = (early_idx >= 0) && (early_idx != nwords - 1);
      exp_missing = !final_last;
`else
      exp_early = 1'b0;
      exp_missing = 1'b0;
`endif
      chk("status", {77'd0, status}, {77'd0, exp_missing, exp_early, gap_at >= 0});
      if (rdy_mode == 0 && gap_at < 0) begin
         chk("throughput", 80'(last_beat - first_beat), 80'(nb - 1));
         chk("latency", 80'(first_beat - first_acc), 80'd2);
      end
   endtask

   initial begin
      axis.AxisData = '0;
      axis.AxisDataVld = 1'b0;
      axis.AxisDataEnd = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("rst_dataOut", dataOut, 80'd0);
      chk("rst_vld", {79'd0, data_vld}, 80'd0);
      chk("rst_ls_fe", {78'd0, line_start, frame_end}, 80'd0);
      chk("rst_status", {77'd0, status}, 80'd0);
      chk("rst_count", {48'd0, inDataCount}, 80'd0);
      chk("rst_ready", {79'd0, axis.AxisDataRead}, 80'd0);

      // 10-bit, slot0 = 0x3FF, two lines of two beats
      run_frame(1'b1, 16, 2, 0, -1, -1, 1'b1, 1, -1);
      // 8-bit byte ramp, one line
      run_frame(1'b0, 16, 1, 0, -1, -1, 1'b1, 2, -1);
      // 10-bit with lane_rdy toggling
      run_frame(1'b1, 32, 3, 1, -1, -1, 1'b1, 0, -1);
      // 3-clock stream gap with lane_rdy high
      run_frame(1'b1, 32, 2, 0, 2, -1, 1'b1, 0, -1);
      // tlast on word 2 of 4, none on word 4
      run_frame(1'b1, 16, 2, 0, -1, 1, 1'b0, 0, -1);
      // 8-bit with random lane_rdy
      run_frame(1'b0, 48, 2, 2, -1, -1, 1'b1, 0, -1);
      // reset after word 2, then a new frame with the opposite packing
      run_frame(1'b1, 32, 1, 0, -1, -1, 1'b1, 0, 2);
      run_frame(1'b0, 32, 1, 0, -1, -1, 1'b1, 0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axis_image_unpacker.md
# axis_image_unpacker

Stream-to-lane unpacker for the image playback path: consumes the 128-bit AXIS image stream produced by the DMA read channel (MM2S) and regenerates lane-parallel sensor-format pixel beats (LANE×DWIDTH) for the downstream image pipeline. It undoes the DMA write-side packing in both 8-bit and 10-bit image modes, counts lines and columns, generates line/frame markers and flags stream framing errors.

## Interface
- LANE, 8, pixel lanes per output beat; fixed at 8
- DWIDTH, 10, bits per lane pixel; fixed at 10
- sys_clk  in  1  system clock; all logic in this domain
- frame_rst  in  1  reset, asynchronous, active-high; clock sys_clk
- AxisData  in  128  stream word
- AxisDataVld  in  1  stream valid (tvalid)
- AxisDataEnd  in  1  stream last (tlast)
- AxisDataRead  out  1  stream ready (tready), combinational
- imageWidth  in  32  pixels per line, multiple of 16
- imageHeight  in  32  lines per frame, ≥1
- imageMode  in  1  1 = 10-bit packing, 0 = 8-bit packing
- playEnable  in  1  level; enables stream acceptance
- lane_rdy  in  1  downstream accepts a beat this cycle
- dataOut  out  80  lane pixel beat, lane k at [k*10+9:k*10]
- data_vld  out  1  dataOut valid
- line_start  out  1  pulse with first beat of each line
- frame_end  out  1  pulse with last beat of frame
- status  out  3  {missing_last, early_last, underrun}, sticky
- inDataCount  out  32  pixels accepted from stream this frame

## Operation
- While frame_rst high: imageMode, imageWidth, imageHeight captured into mode_q, width_q, height_q; all state cleared. Held constant otherwise.
- Holding register hold (128 b), flag hv, half pointer hp. Word accepted when AxisDataVld & AxisDataRead: hold←AxisData, hv←1, hp←0.
- AxisDataRead = playEnable & ~done & (~hv | (lane_rdy & lastBeatOfHold)).
- Beat consumed when hv & lane_rdy. lastBeatOfHold = mode_q ? 1 : hp.
- 8-bit mode (2 beats/word, low half first): half h = hold[64h+63:64h]; byte i → dataOut[(7-i)*10+9:(7-i)*10+2], bits [1:0] of each lane = 0.
- 10-bit mode (1 beat/word): slot i bits [16i+9:16i] → dataOut[(7-i)*10+9:(7-i)*10]; slot bits [15:10] discarded.
- Counters: colCnt 1..width_q/8, lineCnt 1..height_q, advance per consumed beat; colCnt wraps to 1 and lineCnt increments at line end.
- done set on consuming beat with colCnt==width_q/8 & lineCnt==height_q; cleared only by frame_rst. While done, no further words accepted.
- inDataCount += mode_q ? 8 : 16 per accepted word.
- underrun (status[0]): lane_rdy & ~hv & ~done & playEnable, after first word of frame accepted.
- Deasserting playEnable mid-frame: stops acceptance only; buffered word still drains; counters hold.

## Timing
- Reset values: AxisDataRead 0 (during reset, since hv cleared it follows playEnable after release), dataOut 0, data_vld 0, line_start 0, frame_end 0, status 0, inDataCount 0.
- dataOut, data_vld, line_start, frame_end registered: beat consumed at edge N appears on cycle after N.
- Latency word accept → data_vld: 2 clocks.
- Throughput with lane_rdy and AxisDataVld continuously high: 10-bit 1 word/clk; 8-bit 1 word/2 clk; no bubbles.
- Accept and consume of previous word's last beat in same cycle: both occur; hv stays 1.
- lane_rdy low: hold and hp frozen, data_vld 0 next cycle.
- frame_rst mid-frame: immediate clear, stream word in flight dropped.

## Configuration
- AXIS_LAST_CHECK_EN defined: early_last (status[1]) set when AxisDataEnd accepted on word not final word of frame; missing_last (status[2]) set when final word accepted with AxisDataEnd low. Flags sticky until frame_rst.
- Undefined: AxisDataEnd ignored, status[2:1] tied 0; underrun unaffected.

## Test plan
- 10-bit, width 16, height 2, lane_rdy=1: 4 words, slot0=0x3FF others 0 → 4 beats back-to-back, lane7=0x3FF, line_start on beats 1,3, frame_end on beat 4, inDataCount=32.
- 8-bit, width 16, height 1: word bytes 0x00..0x0F → beat1 lane7=0x000, lane0=0x07<<2; beat2 lane7=0x08<<2, lane0=0x0F<<2; AxisDataRead low every other cycle.
- lane_rdy toggling 1/0 in 10-bit mode → one beat per 2 clocks, no data lost, order preserved, status=0.
- lane_rdy high, AxisDataVld gap of 3 clocks mid-frame → status[0]=1.
- AXIS_LAST_CHECK_EN: AxisDataEnd on word 2 of 4 → status[1]=1; none on word 4 → status[2]=1; without macro both 0.
- frame_rst asserted after word 2: all outputs 0 next cycle; new frame with imageMode flipped uses new packing.
